// File: rtl/imem_access_ctrl_if.sv
// Bus bundle for imem_access_ctrl: loader port, fetch port and the
// instruction-memory side.
//   slave  : the access controller (drives ld_ready, instr*, pc, busy, mem_*)
//   master : requesters and memory (drive ld_*, fetch_req, branch_*, mem_out)
interface imem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) ();
    logic                ld_valid;
    logic [ADDR_W-1:0]   ld_addr;
    logic [DATA_W-1:0]   ld_data;
    logic                ld_ready;
    logic                fetch_req;
    logic                branch_en;
    logic [ADDR_W-1:0]   branch_addr;
    logic [DATA_W-1:0]   instr;
    logic                instr_valid;
    logic [ADDR_W-1:0]   pc;
    logic                busy;
    logic [2*DATA_W-1:0] mem_in;
    logic                mem_done;
    logic                mem_rw;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_out;

    modport slave (
        input  ld_valid, ld_addr, ld_data, fetch_req, branch_en, branch_addr, mem_out,
        output ld_ready, instr, instr_valid, pc, busy, mem_in, mem_done, mem_rw, mem_addr
    );

    modport master (
        output ld_valid, ld_addr, ld_data, fetch_req, branch_en, branch_addr, mem_out,
        input  ld_ready, instr, instr_valid, pc, busy, mem_in, mem_done, mem_rw, mem_addr
    );
endinterface

// File: rtl/imem_access_ctrl.sv
// imem_access_ctrl: sequences all access to the instruction memory.
// A program loader (writes) and the fetch port (reads at the PC) share the
// memory; they are arbitrated round-robin in IDLE, one transaction at a time.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - imem_access_ctrl_if.slave: loader handshake (ld_*), fetch/branch
//          control, instr/instr_valid/pc/busy status, memory write port
//          (mem_in, mem_done strobe, mem_rw) and read port (mem_addr, mem_out)
module imem_access_ctrl #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 8,
    parameter logic [ADDR_W-1:0] START_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    imem_access_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_STROBE, WR_GAP, RD_ADDR, RD_CAP
    } state_t;

    state_t                state, state_n;
    logic                  last_fetch, last_fetch_n;   // 1: last grant went to fetch
    logic [ADDR_W-1:0]     pc_q, pc_n;
    logic [ADDR_W-1:0]     maddr_q, maddr_n;
    logic [DATA_W-1:0]     instr_q, instr_n;
    logic                  ivalid_q, ivalid_n;
    logic                  done_q, done_n;
    logic                  rw_q, rw_n;
    logic [2*DATA_W-1:0]   min_q, min_n;
    logic [ADDR_W-1:0]     fa;
    logic                  grant_ld, grant_fetch;

    // Round-robin: on a tie the loader wins unless it was granted last.
    always_comb begin
        grant_ld    = 1'b0;
        grant_fetch = 1'b0;
        if (state == IDLE) begin
            if (bus.ld_valid && (!bus.fetch_req || last_fetch))
                grant_ld = 1'b1;
            else if (bus.fetch_req)
                grant_fetch = 1'b1;
        end
    end

    assign fa = bus.branch_en ? bus.branch_addr : pc_q;

    always_comb begin
        state_n      = state;
        last_fetch_n = last_fetch;
        // A branch outside a fetch grant loads the PC directly, in any state;
        // with a grant it is consumed as the fetch address instead.
        pc_n         = bus.branch_en ? bus.branch_addr : pc_q;
        maddr_n      = maddr_q;
        instr_n      = instr_q;
        ivalid_n     = 1'b0;
        done_n       = done_q;
        rw_n         = rw_q;
        min_n        = min_q;
        unique case (state)
            IDLE: begin
                if (grant_ld) begin
                    min_n        = {bus.ld_addr, bus.ld_data};
                    rw_n         = 1'b0;
                    last_fetch_n = 1'b0;
                    state_n      = WR_SETUP;
                end else if (grant_fetch) begin
                    maddr_n      = fa;
                    pc_n         = fa + 1'b1;
                    last_fetch_n = 1'b1;
                    state_n      = RD_ADDR;
                end
            end
            WR_SETUP: begin
                done_n  = 1'b1;
                state_n = WR_STROBE;
            end
            WR_STROBE: begin
                done_n  = 1'b0;
                state_n = WR_GAP;
            end
            WR_GAP: begin
                rw_n    = 1'b1;
                state_n = IDLE;
            end
            RD_ADDR: state_n = RD_CAP;
            RD_CAP: begin
                instr_n  = bus.mem_out;
                ivalid_n = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_fetch <= 1'b1;
            pc_q       <= START_PC;
            maddr_q    <= '0;
            instr_q    <= '0;
            ivalid_q   <= 1'b0;
            done_q     <= 1'b0;
            rw_q       <= 1'b1;
            min_q      <= '0;
        end else begin
            state      <= state_n;
            last_fetch <= last_fetch_n;
            pc_q       <= pc_n;
            maddr_q    <= maddr_n;
            instr_q    <= instr_n;
            ivalid_q   <= ivalid_n;
            done_q     <= done_n;
            rw_q       <= rw_n;
            min_q      <= min_n;
        end
    end

    assign bus.ld_ready    = grant_ld;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = ivalid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = (state != IDLE);
    assign bus.mem_in      = min_q;
    assign bus.mem_done    = done_q;
    assign bus.mem_rw      = rw_q;
    assign bus.mem_addr    = maddr_q;
endmodule

// File: tb/tb_imem_access_ctrl.sv
// Self-checking bench for imem_access_ctrl with a behavioural 256x8 memory
// (write on rising mem_done, read data refreshed on falling clk when mem_rw=1).
module tb_imem_access_ctrl;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    imem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

    imem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .START_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    int         done_edges = 0;
    logic [7:0] exp_q [$];
    bit         grant_q [$];
    logic [7:0] exp_pc;

    // Memory write port
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);
        forever begin
            @(posedge ifc.mem_done);
            mem[ifc.mem_in[15:8]] = ifc.mem_in[7:0];
            done_edges++;
        end
    end

    // Memory read port
    always @(negedge clk)
        if (ifc.mem_rw) ifc.mem_out <= mem[ifc.mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] a, input logic [7:0] d, output logic rdy);
        ifc.ld_valid = 1'b1;
        ifc.ld_addr  = a;
        ifc.ld_data  = d;
        #1;
        rdy = ifc.ld_ready;
        tick();
        ifc.ld_valid = 1'b0;
        repeat (3) tick();
        ref_mem[a] = d;
    endtask

    task automatic do_fetch(input bit br, input logic [7:0] br_a,
                            input bit mid, input logic [7:0] mid_a,
                            output logic [7:0] got, output int lat,
                            output logic [7:0] addr_seen, output logic [7:0] pc_end);
        ifc.fetch_req   = 1'b1;
        ifc.branch_en   = br;
        ifc.branch_addr = br_a;
        got = '0;
        lat = 0;
        addr_seen = '0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 1) begin
                addr_seen       = ifc.mem_addr;
                ifc.branch_en   = mid;
                ifc.branch_addr = mid_a;
            end else if (n == 2) begin
                ifc.branch_en = 1'b0;
            end
            if (ifc.instr_valid) begin
                got = ifc.instr;
                lat = n;
                break;
            end
        end
        ifc.fetch_req = 1'b0;
        ifc.branch_en = 1'b0;
        pc_end = ifc.pc;
    endtask

    task automatic test_reset();
        int base;
        rst = 1'b1;
        repeat (3) tick();
        rst  = 1'b0;
        base = done_edges;
        repeat (4) tick();
        tests++; if (ifc.pc !== 8'h00) begin fails++; $display("FAIL reset_pc: got %h expected 00", ifc.pc); end
        tests++; if (ifc.instr !== 8'h00) begin fails++; $display("FAIL reset_instr: got %h expected 00", ifc.instr); end
        tests++; if (ifc.instr_valid !== 1'b0) begin fails++; $display("FAIL reset_instr_valid: got %b expected 0", ifc.instr_valid); end
        tests++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", ifc.busy); end
        tests++; if (ifc.mem_rw !== 1'b1) begin fails++; $display("FAIL reset_mem_rw: got %b expected 1", ifc.mem_rw); end
        tests++; if (ifc.mem_done !== 1'b0) begin fails++; $display("FAIL reset_mem_done: got %b expected 0", ifc.mem_done); end
        tests++; if (ifc.mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr: got %h expected 00", ifc.mem_addr); end
        tests++; if (ifc.mem_in !== 16'h0000) begin fails++; $display("FAIL reset_mem_in: got %h expected 0000", ifc.mem_in); end
        tests++; if (done_edges !== base) begin fails++; $display("FAIL reset_no_strobe: got %0d edges expected 0", done_edges - base); end
        exp_pc = 8'h00;
    endtask

    task automatic test_load_fetch();
        logic       rdy;
        logic [7:0] got, a, pce, e;
        int         lat, base;
        base = done_edges;
        do_load(8'h00, 8'hA5, rdy);
        tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL load0_ready: got %b expected 1", rdy); end
        do_load(8'h01, 8'h3C, rdy);
        tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL load1_ready: got %b expected 1", rdy); end
        tests++; if (done_edges - base !== 2) begin fails++; $display("FAIL load_strobes: got %0d expected 2", done_edges - base); end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(ref_mem[exp_pc]);
            do_fetch(1'b0, 8'h00, 1'b0, 8'h00, got, lat, a, pce);
            exp_pc = exp_pc + 8'h01;
            e = exp_q.pop_front();
            tests++; if (got !== e) begin fails++; $display("FAIL fetch%0d_instr: got %h expected %h", k, got, e); end
            tests++; if (lat !== 3) begin fails++; $display("FAIL fetch%0d_latency: got %0d expected 3", k, lat); end
        end
        tests++; if (ifc.pc !== 8'h03) begin fails++; $display("FAIL fetch_pc_end: got %h expected 03", ifc.pc); end
    endtask

    task automatic test_arbitration();
        int  got_n = 0;
        int  bad_ready = 0;
        bit  g, eg;
        grant_q = '{1'b0, 1'b1, 1'b0, 1'b1};   // 0 = load, 1 = fetch
        ifc.ld_addr   = 8'h20;
        ifc.ld_data   = 8'h11;
        ifc.ld_valid  = 1'b1;
        ifc.fetch_req = 1'b1;
        #1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (!ifc.busy) begin
                if (got_n == 4) break;
                g  = !ifc.ld_ready;
                eg = grant_q.pop_front();
                tests++; if (g !== eg) begin fails++; $display("FAIL arb_grant%0d: got %0d expected %0d", got_n, g, eg); end
                if (eg) exp_pc = exp_pc + 8'h01;
                else    ref_mem[8'h20] = 8'h11;
                got_n++;
            end else if (ifc.ld_ready) begin
                bad_ready++;
            end
            tick();
        end
        ifc.ld_valid  = 1'b0;
        ifc.fetch_req = 1'b0;
        tests++; if (got_n !== 4) begin fails++; $display("FAIL arb_count: got %0d grants expected 4", got_n); end
        tests++; if (bad_ready !== 0) begin fails++; $display("FAIL arb_ready_busy: got %0d cycles expected 0", bad_ready); end
        tests++; if (ifc.pc !== exp_pc) begin fails++; $display("FAIL arb_pc: got %h expected %h", ifc.pc, exp_pc); end
        tick();
    endtask

    task automatic test_wrap();
        logic [7:0] got, a, pce, e;
        int         lat;
        ifc.branch_en   = 1'b1;
        ifc.branch_addr = 8'hFF;
        tick();
        ifc.branch_en = 1'b0;
        tests++; if (ifc.pc !== 8'hFF) begin fails++; $display("FAIL wrap_branch_idle: got %h expected ff", ifc.pc); end
        exp_q.push_back(ref_mem[8'hFF]);
        do_fetch(1'b0, 8'h00, 1'b0, 8'h00, got, lat, a, pce);
        e = exp_q.pop_front();
        tests++; if (a !== 8'hFF) begin fails++; $display("FAIL wrap_addr: got %h expected ff", a); end
        tests++; if (got !== e) begin fails++; $display("FAIL wrap_instr: got %h expected %h", got, e); end
        tests++; if (pce !== 8'h00) begin fails++; $display("FAIL wrap_pc: got %h expected 00", pce); end
        exp_q.push_back(ref_mem[8'h00]);
        do_fetch(1'b0, 8'h00, 1'b0, 8'h00, got, lat, a, pce);
        e = exp_q.pop_front();
        tests++; if (a !== 8'h00) begin fails++; $display("FAIL wrap_next_addr: got %h expected 00", a); end
        tests++; if (got !== e) begin fails++; $display("FAIL wrap_next_instr: got %h expected %h", got, e); end
    endtask

    task automatic test_branch();
        logic [7:0] got, a, pce, e;
        int         lat;
        exp_q.push_back(ref_mem[8'h40]);
        do_fetch(1'b1, 8'h40, 1'b0, 8'h00, got, lat, a, pce);
        e = exp_q.pop_front();
        tests++; if (a !== 8'h40) begin fails++; $display("FAIL branch_addr: got %h expected 40", a); end
        tests++; if (pce !== 8'h41) begin fails++; $display("FAIL branch_pc: got %h expected 41", pce); end
        tests++; if (got !== e) begin fails++; $display("FAIL branch_instr: got %h expected %h", got, e); end
        exp_q.push_back(ref_mem[8'h41]);
        do_fetch(1'b0, 8'h00, 1'b1, 8'h80, got, lat, a, pce);
        e = exp_q.pop_front();
        tests++; if (got !== e) begin fails++; $display("FAIL busy_branch_instr: got %h expected %h", got, e); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL busy_branch_latency: got %0d expected 3", lat); end
        tests++; if (pce !== 8'h80) begin fails++; $display("FAIL busy_branch_pc: got %h expected 80", pce); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] orig;
        int         base, pulses;
        orig = ref_mem[8'h10];
        base = done_edges;
        // Abort in WR_SETUP
        ifc.ld_addr = 8'h10; ifc.ld_data = 8'h77; ifc.ld_valid = 1'b1;
        tick();
        ifc.ld_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        tests++; if (mem[8'h10] !== orig) begin fails++; $display("FAIL rst_setup_mem: got %h expected %h", mem[8'h10], orig); end
        tests++; if (done_edges !== base) begin fails++; $display("FAIL rst_setup_strobe: got %0d edges expected 0", done_edges - base); end
        tests++; if (ifc.mem_rw !== 1'b1 || ifc.busy !== 1'b0) begin fails++; $display("FAIL rst_setup_state: got rw=%b busy=%b expected rw=1 busy=0", ifc.mem_rw, ifc.busy); end
        // Reset in WR_GAP: write already committed
        ifc.ld_valid = 1'b1;
        tick();
        ifc.ld_valid = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        ref_mem[8'h10] = 8'h77;
        tick();
        tests++; if (mem[8'h10] !== ref_mem[8'h10]) begin fails++; $display("FAIL rst_gap_mem: got %h expected %h", mem[8'h10], ref_mem[8'h10]); end
        tests++; if (done_edges - base !== 1) begin fails++; $display("FAIL rst_gap_strobe: got %0d edges expected 1", done_edges - base); end
        // Reset in RD_CAP: no instr_valid
        ifc.fetch_req = 1'b1;
        tick(); tick();
        rst = 1'b1; ifc.fetch_req = 1'b0;
        pulses = 0;
        tick();
        rst = 1'b0;
        if (ifc.instr_valid) pulses++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ifc.instr_valid) pulses++;
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL rst_read_valid: got %0d pulses expected 0", pulses); end
        tests++; if (ifc.instr !== 8'h00) begin fails++; $display("FAIL rst_read_instr: got %h expected 00", ifc.instr); end
        tests++; if (ifc.pc !== 8'h00) begin fails++; $display("FAIL rst_read_pc: got %h expected 00", ifc.pc); end
    endtask

    initial begin
        ifc.ld_valid    = 1'b0;
        ifc.ld_addr     = '0;
        ifc.ld_data     = '0;
        ifc.fetch_req   = 1'b0;
        ifc.branch_en   = 1'b0;
        ifc.branch_addr = '0;
        exp_pc          = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'((i * 37 + 11) & 8'hFF);
        test_reset();
        test_load_fetch();
        test_arbitration();
        test_wrap();
        test_branch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end
endmodule
